// File: rtl/fetch_stage.sv
// fetch_stage: IF stage owning the PC, driving a 1-cycle ROM, holding across stalls, pre-decoding type.
// Optional static j/jal redirect at fetch when FETCH_PREDICT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IMEM_AW  = 12,
  parameter logic [31:0] NOP_WORD = 32'h0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        pc_out,
  output logic [31:0]        ir_out,
  output logic [1:0]         type_out,
  output logic               valid_out,
  output logic               fd_flush,
  output logic               pred_taken
);
  logic [31:0] fpc_q, fpc_d, inf_pc_q, inf_pc_d, hold_ir_q, hold_ir_d;
  logic        inf_valid_q, inf_valid_d, held_q, held_d;
  logic [4:0]  op;
  logic        predict;
  always_comb begin
    imem_addr = fpc_q[IMEM_AW-1:0];
    ir_out = !inf_valid_q ? NOP_WORD : (held_q ? hold_ir_q : imem_data);
    valid_out = inf_valid_q;
    pc_out = inf_pc_q + 32'd1;
    fd_flush = redirect_valid;
    op = ir_out[31:27];
    type_out = !inf_valid_q ? 2'b00 :
               (op == 5'b00010 || op == 5'b00110) ? 2'b01 :
               (op == 5'b00001 || op == 5'b00011 || op == 5'b00100 || op == 5'b10110) ? 2'b10 :
               (op == 5'b00111 || op == 5'b01000) ? 2'b11 : 2'b00;
`ifdef FETCH_PREDICT_EN
    pred_taken = inf_valid_q && (op == 5'b00001 || op == 5'b00011);
`else
    pred_taken = 1'b0;
`endif
    predict = pred_taken && !stall && !redirect_valid;
    fpc_d = fpc_q;
    inf_pc_d = inf_pc_q;
    inf_valid_d = inf_valid_q;
    hold_ir_d = hold_ir_q;
    held_d = held_q;
    if (redirect_valid) begin
      fpc_d = redirect_pc;
      inf_valid_d = 1'b0;
      held_d = 1'b0;
    end else if (stall) begin
      // only capture on entry from RUN; ROM re-reads fpc so the live word must be parked
      if (inf_valid_q && !held_q) begin
        hold_ir_d = imem_data;
        held_d = 1'b1;
      end
    end else if (predict) begin
      fpc_d = {5'b0, ir_out[26:0]};
      inf_valid_d = 1'b0;
      held_d = 1'b0;
    end else begin
      inf_pc_d = fpc_q;
      inf_valid_d = 1'b1;
      held_d = 1'b0;
      fpc_d = fpc_q + 32'd1;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fpc_q <= RESET_PC;
      inf_pc_q <= '0;
      inf_valid_q <= 1'b0;
      hold_ir_q <= '0;
      held_q <= 1'b0;
    end else begin
      fpc_q <= fpc_d;
      inf_pc_q <= inf_pc_d;
      inf_valid_q <= inf_valid_d;
      hold_ir_q <= hold_ir_d;
      held_q <= held_d;
    end
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline, directly upstream of the F/D latch; feeds its pc, instruction and type inputs.
- Owns the program counter and drives a synchronous instruction ROM with 1-cycle read latency.
- Holds the fetched instruction across stalls.
- Applies branch/jump redirects from execute, with squash and bubble insertion.
- Pre-decodes a 2-bit instruction type.

Parameters:
- RESET_PC, 0, PC loaded on reset.
- IMEM_AW, 12, instruction ROM address width.
- NOP_WORD, 32'h00000000, word emitted for bubbles.

Ports:
- clock  in  1  pipeline clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit stall; same signal drives the F/D latch enable.
- redirect_valid  in  1  execute resolved a taken branch or jump.
- redirect_pc  in  32  redirect target.
- imem_addr  out  IMEM_AW  ROM address, combinational from the fetch PC.
- imem_data  in  32  ROM data for the address presented the previous cycle.
- pc_out  out  32  PC+1 of the instruction on ir_out; goes to F/D pc_in.
- ir_out  out  32  instruction to F/D, or NOP_WORD.
- type_out  out  2  pre-decoded type.
- valid_out  out  1  ir_out is a live instruction.
- fd_flush  out  1  flush to the F/D latch.
- pred_taken  out  1  fetch already redirected on this instruction.

Behaviour:
- State registers:
  - fpc (32): fetch PC.
  - inf_pc (32) / inf_valid: PC and liveness of the word on imem_data.
  - hold_ir (32) / held: stall buffer.
- Reset (async, any cycle, including mid-stall or mid-redirect): fpc=RESET_PC, inf_pc=0, inf_valid=0, held=0, hold_ir=0.
- Outputs while reset is asserted: ir_out=NOP_WORD, valid_out=0, pc_out=1, type_out=00, fd_flush=redirect_valid, pred_taken=0.
- imem_addr = fpc[IMEM_AW-1:0]; upper PC bits are ignored and the address wraps.
- ir_out = !inf_valid ? NOP_WORD : (held ? hold_ir : imem_data).
- valid_out = inf_valid.
- pc_out = inf_pc+1, mod 2^32.
- type_out, from ir_out[31:27] (forced 00 when !inf_valid):
  - 01 for bne 00010, blt 00110.
  - 10 for j 00001, jal 00011, jr 00100, bex 10110.
  - 11 for sw 00111, lw 01000.
  - 00 otherwise.
- States are derived from inf_valid and held:
  - BUBBLE: inf_valid=0.
  - RUN: inf_valid=1, held=0.
  - HOLD: inf_valid=1, held=1.
- Priority per edge: redirect_valid > stall > advance.
- Redirect (stall ignored):
  - fpc<=redirect_pc, inf_valid<=0, held<=0.
  - fd_flush=redirect_valid, combinational, same cycle.
  - Next cycle: imem_addr=redirect_pc, ir_out=NOP_WORD (BUBBLE).
  - The cycle after: the target instruction, with valid_out=1.
- Stall without redirect:
  - fpc and inf_* hold.
  - In RUN: hold_ir<=imem_data, held<=1, moving to HOLD.
  - In HOLD or BUBBLE: no change.
  - ir_out stays constant for the whole stall.
- Advance (no stall, no redirect): inf_pc<=fpc, inf_valid<=1, held<=0, fpc<=fpc+1.
  - From HOLD, the release cycle outputs hold_ir.
  - imem_data the following cycle is the word at the un-advanced fpc.
  - No instruction is lost or duplicated.
- A redirect arriving during HOLD discards hold_ir.
- fpc wraps 32'hFFFFFFFF to 0.
- Steady-state throughput is 1 instruction/cycle. Redirect penalty is 1 bubble beyond the F/D flush.

Optional Feature:
- Macro: FETCH_PREDICT_EN.
- Defined: when the instruction on ir_out is a live j or jal, with no stall and no redirect:
  - fpc<={5'b0, ir_out[26:0]} and inf_valid<=0, squashing the sequential fetch.
  - pred_taken=1 while that instruction is on ir_out.
  - fd_flush is not asserted.
  - This costs 1 bubble.
- Undefined: pred_taken is tied 0, and j/jal follow the normal execute redirect path.

Test Plan:
- Reset release with ROM[0..3]=A,B,C,D -> cycle 1: valid_out=0, ir_out=0; cycles 2-5: ir_out=A,B,C,D with pc_out=1,2,3,4.
- Stall high 3 cycles while ir_out=B (pc_out=2) -> ir_out=B and imem_addr=2 throughout; after release, ir_out sequence B,C,D with no gaps or duplicates.
- redirect_valid=1 with redirect_pc=40 while ir_out=C -> fd_flush=1 that cycle; next cycle ir_out=0, valid_out=0; then ir_out=ROM[40], pc_out=41.
- redirect and stall asserted together during HOLD -> redirect wins, hold discarded; next cycle BUBBLE; then ROM[redirect_pc].
- Reset asserted mid-stall, between clock edges -> outputs immediately ir_out=0, valid_out=0; after release, the sequence restarts from ROM[RESET_PC].
- FETCH_PREDICT_EN defined, ROM[5]=j 20 -> pred_taken=1 with ir_out=j, fd_flush=0; next cycle bubble; then ROM[20], pc_out=21. Undefined -> ROM[6] follows and pred_taken=0.
